// File: rtl/tc_pkg.sv
// tc_pkg: phase codes, default durations and lamp decode for the timed traffic controller
package tc_pkg;
  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    AR_A   = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    AR_B   = 3'd5
  } state_t;
  localparam int CNT_W_D   = 4;
  localparam int NS_MIN_D  = 8;
  localparam int Y_TIME_D  = 3;
  localparam int AR_TIME_D = 1;
  localparam int EW_MIN_D  = 4;
  localparam int EW_MAX_D  = 10;
  // {NS_G,NS_Y,NS_R,EW_G,EW_Y,EW_R}; unreachable codes decode to all-red
  function automatic logic [5:0] lamps(state_t s);
    return s == NS_GRN ? 6'b100_001 :
           s == NS_YEL ? 6'b010_001 :
           s == EW_GRN ? 6'b001_100 :
           s == EW_YEL ? 6'b001_010 : 6'b001_001;
  endfunction
endpackage

// File: rtl/tc_phase_timer.sv
// tc_phase_timer: saturating phase timer, cleared on every state transition
module tc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) q <= '0;
    else q <= clr ? '0 : (&q ? q : q + 1'b1);
endmodule

// File: rtl/tc_timed_ctrl.sv
// tc_timed_ctrl: two-road Moore traffic controller with programmable phase durations
module tc_timed_ctrl
  import tc_pkg::*;
#(
  parameter int CNT_W   = CNT_W_D,
  parameter int NS_MIN  = NS_MIN_D,
  parameter int Y_TIME  = Y_TIME_D,
  parameter int AR_TIME = AR_TIME_D,
  parameter int EW_MIN  = EW_MIN_D,
  parameter int EW_MAX  = EW_MAX_D
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sensor,
  output logic [CNT_W-1:0] Q,
  output logic [2:0]       phase,
  output logic             NS_G,
  output logic             NS_Y,
  output logic             NS_R,
  output logic             EW_G,
  output logic             EW_Y,
  output logic             EW_R
);
  localparam int LIM = 2 ** CNT_W;
  if (AR_TIME < 1 || EW_MAX < EW_MIN || NS_MIN > LIM || Y_TIME > LIM ||
      AR_TIME > LIM || EW_MIN > LIM || EW_MAX > LIM) begin : g_bad_params
    $error("tc_timed_ctrl: illegal duration parameters");
  end
  localparam logic [CNT_W-1:0] NS_L = CNT_W'(NS_MIN - 1);
  localparam logic [CNT_W-1:0] Y_L  = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] A_L  = CNT_W'(AR_TIME - 1);
  localparam logic [CNT_W-1:0] EN_L = CNT_W'(EW_MIN - 1);
  localparam logic [CNT_W-1:0] EX_L = CNT_W'(EW_MAX - 1);
  state_t           state, nxt;
  logic             req;
  logic [CNT_W-1:0] q;
  tc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .resetn(resetn),
    .clr   (nxt != state),
    .q     (q)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= NS_GRN;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      NS_GRN:  nxt = (q >= NS_L && (req || sensor)) ? NS_YEL : NS_GRN;
      NS_YEL:  nxt = q == Y_L ? AR_A : NS_YEL;
      AR_A:    nxt = q == A_L ? EW_GRN : AR_A;
      EW_GRN:  nxt = ((q >= EN_L && !sensor) || q == EX_L) ? EW_YEL : EW_GRN;
      EW_YEL:  nxt = q == Y_L ? AR_B : EW_YEL;
      AR_B:    nxt = q == A_L ? NS_GRN : AR_B;
      default: nxt = NS_GRN;
    endcase
  end
  // entering EW green consumes the request, even if sensor is high that cycle
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) req <= 1'b0;
    else if (nxt == EW_GRN && state != EW_GRN) req <= 1'b0;
    else if (sensor && (state == NS_GRN || state == NS_YEL || state == AR_A)) req <= 1'b1;
  assign Q = q;
  assign phase = state;
  assign {NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R} = lamps(state);
endmodule

// File: tb/tb_tc_timed_ctrl.sv
// tb_tc_timed_ctrl: directed scenarios checked against a phase/elapsed-time model of the controller
module tb_tc_timed_ctrl;
  localparam int NS_MIN = 8, Y_TIME = 3, AR_TIME = 1, EW_MIN = 4, EW_MAX = 10;
  logic clock = 0, resetn = 0, sensor = 0;
  logic [3:0] q;
  logic [2:0] phase;
  logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  int n_chk = 0, n_fail = 0;
  int cyc;
  int ph_h[64], q_h[64], rq_h[64];
  int m_ph, m_t;
  bit m_req;
  int lastg;
  bit seen_ar;

  tc_timed_ctrl dut (
    .clock(clock), .resetn(resetn), .sensor(sensor), .Q(q), .phase(phase),
    .NS_G(ns_g), .NS_Y(ns_y), .NS_R(ns_r), .EW_G(ew_g), .EW_Y(ew_y), .EW_R(ew_r)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // phase order 0..5 is cyclic; each phase ends once it has lasted its required duration
  function automatic bit leaves(int ph, int t, bit s, bit r);
    int d = t + 1;
    if (ph == 0) return d >= NS_MIN && (r || s);
    if (ph == 1 || ph == 4) return d == Y_TIME;
    if (ph == 2 || ph == 5) return d == AR_TIME;
    return (d >= EW_MIN && !s) || d == EW_MAX;
  endfunction

  always @(posedge clock or negedge resetn)
    if (!resetn) begin
      m_ph <= 0; m_t <= 0; m_req <= 0; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (leaves(m_ph, m_t, sensor, m_req)) begin
        m_ph <= (m_ph + 1) % 6;
        m_t <= 0;
        m_req <= m_ph == 2 ? 1'b0 : (m_req || (m_ph <= 2 && sensor));
      end else begin
        m_t <= m_t + 1;
        m_req <= m_req || (m_ph <= 2 && sensor);
      end
    end

  always @(negedge clock)
    if (!resetn) begin
      lastg = -1;
      seen_ar = 0;
    end else begin
      if (cyc < 64) begin
        ph_h[cyc] = int'(phase);
        q_h[cyc] = int'(q);
        rq_h[cyc] = int'(dut.req);
      end
      chk("phase", phase, m_ph);
      chk("Q", q, m_t > 15 ? 15 : m_t);
      chk("lamps", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r},
          {m_ph == 0, m_ph == 1, m_ph >= 2, m_ph == 3, m_ph == 4, m_ph != 3 && m_ph != 4});
      chk("req", dut.req, m_req);
      chk("ns_onehot", 32'(ns_g) + 32'(ns_y) + 32'(ns_r), 1);
      chk("ew_onehot", 32'(ew_g) + 32'(ew_y) + 32'(ew_r), 1);
      chk("two_greens", ns_g & ew_g, 0);
      if (phase == 3'd2 || phase == 3'd5) seen_ar = 1;
      if (ns_g || ew_g) begin
        if (lastg != -1 && lastg != int'(ew_g)) chk("allred_gap", seen_ar, 1);
        lastg = int'(ew_g);
        seen_ar = 0;
      end
    end

  task automatic start(bit s);
    resetn = 0;
    sensor = s;
    repeat (2) @(negedge clock);
    chk("rst_Q", q, 0);
    chk("rst_phase", phase, 0);
    chk("rst_lamps", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}, 6'b100_001);
    for (int i = 0; i < 64; i++) begin ph_h[i] = -1; q_h[i] = -1; rq_h[i] = -1; end
    #1 resetn = 1;
  endtask

  task automatic run(int n, int lo, int hi);
    for (int k = 0; k < n; k++) begin
      sensor = cyc >= lo && cyc <= hi;
      @(negedge clock);
    end
  endtask

  task automatic check_s1();
    chk("s1_ph7", ph_h[7], 0);
    chk("s1_ph8", ph_h[8], 1);
    chk("s1_ph10", ph_h[10], 1);
    chk("s1_ph11", ph_h[11], 2);
    chk("s1_ph12", ph_h[12], 3);
    chk("s1_ph21", ph_h[21], 3);
    chk("s1_q21", q_h[21], 9);
    chk("s1_ph22", ph_h[22], 4);
    chk("s1_ph25", ph_h[25], 5);
    chk("s1_ph26", ph_h[26], 0);
  endtask

  initial begin
    start(1);
    run(30, 0, 1000);
    check_s1();

    start(0);
    run(40, 1000, 1000);
    chk("s2_q15", q_h[15], 15);
    chk("s2_q20", q_h[20], 15);
    chk("s2_q35", q_h[35], 15);
    chk("s2_ph35", ph_h[35], 0);

    start(0);
    run(20, 2, 2);
    chk("s3_req2", rq_h[2], 0);
    chk("s3_req3", rq_h[3], 1);
    chk("s3_ph7", ph_h[7], 0);
    chk("s3_ph8", ph_h[8], 1);
    chk("s3_req11", rq_h[11], 1);
    chk("s3_ph12", ph_h[12], 3);
    chk("s3_req12", rq_h[12], 0);

    start(1);
    run(20, 0, 13);
    chk("s4_ph15", ph_h[15], 3);
    chk("s4_q15", q_h[15], 3);
    chk("s4_ph16", ph_h[16], 4);

    start(1);
    run(23, 0, 1000);
    chk("s5_pre", phase, 4);
    #2 resetn = 0;
    #1;
    chk("s5_async_lamps", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}, 6'b100_001);
    chk("s5_async_Q", q, 0);
    chk("s5_async_phase", phase, 0);
    start(1);
    run(30, 0, 1000);
    check_s1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
